// File: rtl/rr_mux_array.sv
// rr_mux_array: registered NCH:1 mux with round-robin or fixed-select arbitration and valid/ready flow control
module rr_mux_array #(
  parameter int WIDTH = 4,
  parameter int NCH = 4,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);
  logic [WIDTH-1:0] ch_data [NCH];
  logic [SEL_W-1:0] ptr_q, ptr_d, ch_q, ch_d, gnt, cand;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d, gnt_vld, free, load;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end
  assign free = !valid_q || out_ready;
  assign load = free && gnt_vld;
  assign in_ready = (rst_n && load) ? NCH'(1) << gnt : '0;
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_ch = ch_q;
  // grant: scan ptr+NCH down to ptr+1 so the channel just after ptr wins last, ptr itself lowest priority
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    cand = '0;
    if (mode) begin
      gnt = sel;
      gnt_vld = (int'(sel) < NCH) && in_valid[sel];
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        cand = SEL_W'((int'(ptr_q) + k) % NCH);
        if (in_valid[cand]) begin
          gnt = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end
  // next state: load winner, drop valid on drain without a new word, pointer follows round-robin grants only
  always_comb begin
    valid_d = load ? 1'b1 : (free ? 1'b0 : valid_q);
    data_d = load ? ch_data[gnt] : data_q;
    ch_d = load ? gnt : ch_q;
    ptr_d = (load && !mode) ? gnt : ptr_q;
  end
  // output register and pointer; reset leaves channel 0 with first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
      ch_q <= '0;
      ptr_q <= SEL_W'(NCH - 1);
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rr_mux_array.sv
// tb_rr_mux_array: directed stimulus with a behavioural arbitration model checked every cycle
module tb_rr_mux_array;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, mode = 0, out_ready = 0, out_valid;
  logic [1:0] sel = 0, out_ch;
  logic [N-1:0] in_valid = 0, in_ready;
  logic [N*W-1:0] in_data = {8'h13, 8'h12, 8'h11, 8'h10};
  logic [W-1:0] out_data;
  int n_chk = 0, n_pass = 0;
  int m_ptr = N - 1, m_c = 0;
  logic m_v = 0;
  logic [W-1:0] m_d = 0;
  rr_mux_array #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  function automatic int model_grant();
    int order[$];
    if (!rst_n || !(!m_v || out_ready)) return -1;
    if (mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction
  always @(negedge rst_n) begin
    m_v = 0; m_d = 0; m_c = 0; m_ptr = N - 1;
  end
  always @(posedge clk) if (rst_n) begin
    int g;
    g = model_grant();
    if (g >= 0) begin
      m_v = 1; m_d = in_data[g*W +: W]; m_c = g;
      if (!mode) m_ptr = g;
    end else if (out_ready) m_v = 0;
  end
  always @(negedge clk) begin
    int g;
    g = model_grant();
    chk("in_ready", in_ready, g >= 0 ? 32'(1) << g : 0);
    chk("out_valid", out_valid, m_v);
    chk("out_data", out_data, m_d);
    chk("out_ch", out_ch, m_c);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    step(); step();
    rst_n = 1; mode = 0; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_ch", out_ch, i % 4);
      chk("rr_data", out_data, 8'h10 + i % 4);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_ch", out_ch, i % 2 ? 3 : 1);
      chk("alt_no02", in_ready & 4'b0101, 0);
    end
    mode = 1; sel = 2; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fix_ch", out_ch, 2);
      chk("fix_data", out_data, 8'h12);
    end
    sel = 3; in_valid = 4'b0111;
    #1 chk("fix_nogrant", in_ready, 0);
    step();
    chk("fix_drop", out_valid, 0);
    chk("fix_hold", out_ch, 2);
    mode = 0; in_valid = 4'b1111;
    step();
    chk("bp_load", out_ch, 0);
    out_ready = 0;
    #1 chk("bp_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data", out_data, 8'h10);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("bp_release", in_ready, 4'b0010);
    step();
    chk("bp_nobubble", {out_valid, 6'(out_ch), out_data}, {1'b1, 6'd1, 8'h11});
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_ch", out_ch, 2);
      chk("single_v", out_valid, 1);
    end
    mode = 1; sel = 0; in_valid = 4'b0001;
    step();
    chk("sw_ch", out_ch, 0);
    mode = 0; in_valid = 4'b1111;
    step();
    chk("ptr_kept", out_ch, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ch", out_ch, 0);
    chk("arst_ready", in_ready, 0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_ch", out_ch, 0);
    chk("post_rst_v", out_valid, 1);
    in_valid = 0;
    step(); step();
    chk("idle_v", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
